// File: rtl/rv32i_rf_pkg.sv
// Shared types and constants for the RV32I register-file requester.
// Holds the requester state encoding and the register-file geometry.
package rv32i_rf_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WB     = 3'd1,
        ST_RD_RS1 = 3'd2,
        ST_RD_RS2 = 3'd3,
        ST_OUT    = 3'd4
    } rf_req_state_e;

endpackage

// File: rtl/rv32i_regfile_requester.sv
// Decode-side register-file requester: serialises writebacks and rs1/rs2 reads onto one RF port.
// Define RF_WB_BYPASS_EN to add a one-entry bypass of the last completed write.
module rv32i_regfile_requester
    import rv32i_rf_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_dec_valid,
    output logic              o_dec_ready,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    input  logic              i_uses_rs2,
    output logic              o_op_valid,
    input  logic              i_op_ready,
    output logic [WIDTH-1:0]  o_rs1_data,
    output logic [WIDTH-1:0]  o_rs2_data,
    input  logic              i_wb_valid,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [WIDTH-1:0]  i_wb_data,
    output logic              o_wb_done,
    output logic              o_rf_rd_en,
    output logic [ADDR_W-1:0] o_rf_reg_addr,
    input  logic [WIDTH-1:0]  i_rf_reg_data,
    input  logic              i_rf_rd_valid,
    output logic              o_rf_wr_en,
    output logic [ADDR_W-1:0] o_rf_dest_addr,
    output logic [WIDTH-1:0]  o_rf_dest_reg_data,
    input  logic              i_rf_wr_valid
);

    rf_req_state_e     state_reg, state_next;
    logic [ADDR_W-1:0] rs1_addr_reg, rs2_addr_reg, dest_addr_reg;
    logic              uses_rs2_reg;
    logic [WIDTH-1:0]  rs1_data_reg, rs2_data_reg, dest_data_reg;
    logic              wb_done_reg, rd_gap_reg;

    logic              wb_pending, in_read, rd_en, rd_done, wr_en, wr_done, wr_commit;
    logic [ADDR_W-1:0] cur_addr;
    logic [WIDTH-1:0]  rd_value;
    logic              byp_hit;
    logic [WIDTH-1:0]  byp_data;

    // The requester keeps i_wb_valid high during the done pulse; mask it so it is not re-served.
    assign wb_pending = i_wb_valid && !wb_done_reg;
    assign in_read    = (state_reg == ST_RD_RS1) || (state_reg == ST_RD_RS2);
    assign cur_addr   = (state_reg == ST_RD_RS2) ? rs2_addr_reg : rs1_addr_reg;
    assign wr_en      = (state_reg == ST_WB) && (dest_addr_reg != REG_ZERO);
    assign wr_done    = (state_reg == ST_WB) && ((dest_addr_reg == REG_ZERO) || i_rf_wr_valid);
    assign wr_commit  = wr_en && i_rf_wr_valid;

    // rd_gap_reg holds rd_en low for the first RD_RS2 cycle so the RF restarts its half sequencing.
    assign rd_en   = in_read && (cur_addr != REG_ZERO) && !byp_hit
                     && !((state_reg == ST_RD_RS2) && rd_gap_reg);
    assign rd_done = in_read && ((cur_addr == REG_ZERO) || byp_hit || (rd_en && i_rf_rd_valid));

    always_comb begin
        rd_value = i_rf_reg_data;
        if (cur_addr == REG_ZERO)
            rd_value = '0;
        else if (byp_hit)
            rd_value = byp_data;
    end

`ifdef RF_WB_BYPASS_EN
    logic [ADDR_W-1:0] byp_addr_reg;
    logic [WIDTH-1:0]  byp_data_reg;
    logic              byp_vld_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byp_addr_reg <= '0;
            byp_data_reg <= '0;
            byp_vld_reg  <= 1'b0;
        end else if (wr_commit) begin
            byp_addr_reg <= dest_addr_reg;
            byp_data_reg <= dest_data_reg;
            byp_vld_reg  <= 1'b1;
        end
    end

    assign byp_hit  = byp_vld_reg && (byp_addr_reg == cur_addr);
    assign byp_data = byp_data_reg;
`else
    logic unused_commit;
    assign unused_commit = wr_commit;
    assign byp_hit       = 1'b0;
    assign byp_data      = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (wb_pending)
                    state_next = ST_WB;
                else if (i_dec_valid)
                    state_next = ST_RD_RS1;
            end
            ST_WB:     if (wr_done) state_next = ST_IDLE;
            ST_RD_RS1: if (rd_done) state_next = uses_rs2_reg ? ST_RD_RS2 : ST_OUT;
            ST_RD_RS2: if (rd_done) state_next = ST_OUT;
            ST_OUT:    if (i_op_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_dec_ready = (state_reg == ST_IDLE) && !wb_pending && !i_rst;
        o_op_valid  = (state_reg == ST_OUT);
        o_rf_rd_en  = rd_en;
        o_rf_wr_en  = wr_en;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rs1_addr_reg  <= '0;
            rs2_addr_reg  <= '0;
            uses_rs2_reg  <= 1'b0;
            rs1_data_reg  <= '0;
            rs2_data_reg  <= '0;
            dest_addr_reg <= '0;
            dest_data_reg <= '0;
            wb_done_reg   <= 1'b0;
            rd_gap_reg    <= 1'b0;
        end else begin
            wb_done_reg <= wr_done;
            rd_gap_reg  <= (state_reg == ST_RD_RS1) && (state_next == ST_RD_RS2);
            if (state_reg == ST_IDLE) begin
                if (wb_pending) begin
                    dest_addr_reg <= i_wb_addr;
                    dest_data_reg <= i_wb_data;
                end else if (i_dec_valid) begin
                    rs1_addr_reg <= i_rs1_addr;
                    rs2_addr_reg <= i_rs2_addr;
                    uses_rs2_reg <= i_uses_rs2;
                    rs1_data_reg <= '0;
                    rs2_data_reg <= '0;
                end
            end
            if (rd_done) begin
                if (state_reg == ST_RD_RS1)
                    rs1_data_reg <= rd_value;
                else
                    rs2_data_reg <= rd_value;
            end
        end
    end

    assign o_rs1_data         = rs1_data_reg;
    assign o_rs2_data         = rs2_data_reg;
    assign o_wb_done          = wb_done_reg;
    assign o_rf_reg_addr      = cur_addr;
    assign o_rf_dest_addr     = dest_addr_reg;
    assign o_rf_dest_reg_data = dest_data_reg;

endmodule
